// File: rtl/adc_joy_scan_ctrl.sv
// adc_joy_scan_ctrl: XADC DRP joystick scanner averaging 2^AVG_LOG2 samples per channel; ADC_JOY_DEADZONE_EN enables centre snap
module adc_joy_scan_ctrl #(
  parameter int          NUM_CH    = 2,
  parameter logic [6:0]  BASE_ADDR = 7'h16,
  parameter int          AVG_LOG2  = 2,
  parameter int          SCAN_DIV  = 1000,
  parameter int          TIMEOUT   = 255,
  parameter int          DEADZONE  = 64
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   scan_en,
  input  logic                   start,
  input  logic                   err_clr,
  output logic [6:0]             drp_daddr,
  output logic                   drp_den,
  output logic                   drp_dwe,
  input  logic [15:0]            drp_do,
  input  logic                   drp_drdy,
  output logic [NUM_CH*12-1:0]   ch_data,
  output logic                   data_valid,
  output logic                   busy,
  output logic                   timeout_err
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RDY, NEXT, PUBLISH} state_e;
  localparam int CH_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int SMP_W = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int TMR_W = $clog2(SCAN_DIV);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);
`ifdef ADC_JOY_DEADZONE_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif
  state_e                   state_q, state_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic [SMP_W-1:0]         smp_q, smp_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [TO_W-1:0]          wcnt_q, wcnt_d;
  logic [TMR_W-1:0]         tmr_q;
  logic [NUM_CH-1:0]        stale_q, stale_d;
  logic [NUM_CH-1:0][11:0]  res_q, res_d, ch_data_q;
  logic                     pend_q, pend_d, per_q, per_d, drop_q, drop_d;
  logic                     err_q, to_set, tick, go;
  logic                     unused_lsb;
  // Centre snap is a compile-time option; the parameter stays referenced in both builds
  function automatic logic [11:0] snap(input logic [11:0] a);
    return (DZ_EN && int'(a) >= 2048 - DEADZONE && int'(a) <= 2048 + DEADZONE) ? 12'h800 : a;
  endfunction
  assign unused_lsb  = ^drp_do[3:0];
  assign tick        = scan_en && tmr_q == TMR_W'(SCAN_DIV - 1);
  assign go          = state_q == IDLE ? (scan_en ? tick : start) :
                       state_q == PUBLISH ? scan_en & (pend_q | tick) : 1'b0;
  assign pend_d      = scan_en & (state_q != IDLE) & (state_q != PUBLISH) & (pend_q | tick);
  assign drp_den     = state_q == ISSUE;
  assign drp_daddr   = drp_den ? BASE_ADDR + 7'(ch_q) : 7'h0;
  assign drp_dwe     = 1'b0;
  assign busy        = state_q == ISSUE || state_q == WAIT_RDY || state_q == NEXT;
  assign data_valid  = state_q == PUBLISH;
  assign ch_data     = ch_data_q;
  assign timeout_err = err_q;
  // Period timer free-runs only while periodic scanning is enabled
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) tmr_q <= '0;
    else tmr_q <= (!scan_en || tick) ? '0 : tmr_q + TMR_W'(1);
  end
  // Scan sequencer: issue, wait, accumulate, advance sample/channel, publish or abort
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    smp_d   = smp_q;
    acc_d   = acc_q;
    wcnt_d  = wcnt_q;
    stale_d = stale_q;
    res_d   = res_q;
    per_d   = per_q;
    to_set  = 1'b0;
    drop_d  = drop_q | (per_q & ~scan_en);
    case (state_q)
      IDLE, PUBLISH: begin
        drop_d  = 1'b0;
        state_d = go ? ISSUE : IDLE;
        if (go) begin
          ch_d    = '0;
          smp_d   = '0;
          acc_d   = '0;
          stale_d = '0;
          per_d   = scan_en;
        end
      end
      ISSUE: begin
        wcnt_d  = '0;
        state_d = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (drp_drdy) begin
          acc_d   = acc_q + ACC_W'(drp_do[15:4]);
          state_d = NEXT;
        end else if (wcnt_q == TO_W'(TIMEOUT - 1)) begin
          to_set        = 1'b1;
          stale_d[ch_q] = 1'b1;
          state_d       = NEXT;
        end else begin
          wcnt_d = wcnt_q + TO_W'(1);
        end
      end
      NEXT: begin
        if (drop_d) begin
          state_d = IDLE;
        end else if (smp_q != SMP_LAST) begin
          smp_d   = smp_q + SMP_W'(1);
          state_d = ISSUE;
        end else begin
          res_d[ch_q] = snap(acc_q[ACC_W-1:AVG_LOG2]);
          acc_d       = '0;
          smp_d       = '0;
          ch_d        = ch_q + CH_W'(1);
          state_d     = ch_q == CH_LAST ? PUBLISH : ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // Sequencer state registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      ch_q    <= '0;
      smp_q   <= '0;
      acc_q   <= '0;
      wcnt_q  <= '0;
      stale_q <= '0;
      res_q   <= '0;
      pend_q  <= 1'b0;
      per_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      smp_q   <= smp_d;
      acc_q   <= acc_d;
      wcnt_q  <= wcnt_d;
      stale_q <= stale_d;
      res_q   <= res_d;
      pend_q  <= pend_d;
      per_q   <= per_d;
      drop_q  <= drop_d;
    end
  end
  // Published words change together on entry to PUBLISH; a new timeout beats err_clr
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ch_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == NEXT && state_d == PUBLISH)
        for (int i = 0; i < NUM_CH; i++)
          if (!stale_q[i]) ch_data_q[i] <= res_d[i];
      err_q <= to_set | (err_q & ~err_clr);
    end
  end
endmodule

// File: tb/tb_adc_joy_scan_ctrl.sv
// tb_adc_joy_scan_ctrl: randomized DRP responder with a scan-level reference model
module tb_adc_joy_scan_ctrl;
  logic        ACLK = 0, ARESETN = 0, scan_en = 0, start = 0, err_clr = 0, drp_drdy = 0;
  logic [15:0] drp_do = 0;
  logic [6:0]  drp_daddr;
  logic        drp_den, drp_dwe, data_valid, busy, timeout_err;
  logic [23:0] ch_data;

  adc_joy_scan_ctrl #(.NUM_CH(2), .BASE_ADDR(7'h16), .AVG_LOG2(2), .SCAN_DIV(200),
                      .TIMEOUT(255), .DEADZONE(64)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .scan_en(scan_en), .start(start), .err_clr(err_clr),
    .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_do(drp_do),
    .drp_drdy(drp_drdy), .ch_data(ch_data), .data_valid(data_valid), .busy(busy),
    .timeout_err(timeout_err));

  always #5 ACLK = ~ACLK;

`ifdef ADC_JOY_DEADZONE_EN
  localparam logic [11:0] DZ820 = 12'h800;
`else
  localparam logic [11:0] DZ820 = 12'h820;
`endif

  int checks = 0, failures = 0;
  int cyc = 0, rd_idx = 0, den_cnt = 0, dv_cnt = 0, dly = 3, t_drop = 0;
  bit rnd_dly = 0, drop1 = 0;
  int acc [2];
  bit stl [2];
  logic [11:0] prev [2];
  logic [15:0] sq [$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] dz(input int a);
`ifdef ADC_JOY_DEADZONE_EN
    if (a >= 2048 - 64 && a <= 2048 + 64) return 12'h800;
`endif
    return 12'(a);
  endfunction

  // DRP responder plus per-cycle comparison against the scan-level model
  initial begin : mon
    int cd, pch;
    bit bprev, eprev;
    logic [15:0] s;
    logic [11:0] e [2];
    cd = 0; pch = 0; bprev = 0; eprev = 0;
    prev[0] = 0; prev[1] = 0;
    forever begin
      @(negedge ACLK);
      cyc++;
      drp_drdy = 1'b0;
      if (!ARESETN) begin
        cd = 0; bprev = 0; eprev = 0; rd_idx = 0;
        prev[0] = 0; prev[1] = 0;
      end else begin
        if (busy && !bprev) begin
          rd_idx = 0; acc[0] = 0; acc[1] = 0; stl[0] = 0; stl[1] = 0;
        end
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            s = sq.size() > 0 ? sq.pop_front() : 16'($urandom);
            drp_do = s;
            drp_drdy = 1'b1;
            acc[pch] += int'(s[15:4]);
          end
        end
        chk("dwe", drp_dwe, 0);
        if (drp_den) begin
          den_cnt++;
          chk("den_in_scan", rd_idx < 8 && busy, 1);
          chk("addr", drp_daddr, 7'h16 + rd_idx / 4);
          pch = rd_idx / 4 > 1 ? 1 : rd_idx / 4;
          rd_idx++;
          if (drop1 && pch == 1) begin
            stl[1] = 1; t_drop = cyc;
          end else cd = rnd_dly ? int'($urandom_range(1, 20)) : dly;
        end else if (cd == 0 && !busy && !drp_drdy && $urandom_range(0, 7) == 0) begin
          drp_do = 16'($urandom);
          drp_drdy = 1'b1;
        end
        if (data_valid) begin
          dv_cnt++;
          for (int c = 0; c < 2; c++) e[c] = stl[c] ? prev[c] : dz(acc[c] / 4);
          chk("dv_reads", rd_idx, 8);
          chk("dv_busy", busy, 0);
          chk("ch_data", ch_data, {e[1], e[0]});
          prev[0] = e[0]; prev[1] = e[1];
        end else chk("ch_hold", ch_data, {prev[1], prev[0]});
        if (timeout_err && !eprev) chk("to_latency", (cyc - t_drop) inside {[255:256]}, 1);
        eprev = timeout_err;
        bprev = busy;
      end
    end
  end

  task automatic tk(input int n = 1);
    repeat (n) begin @(negedge ACLK); #1; end
  endtask

  task automatic pulse_start();
    start = 1; tk(); start = 0;
  endtask

  task automatic wait_dv(input int lim);
    int c0, n;
    c0 = dv_cnt; n = 0;
    while (dv_cnt == c0 && n < lim) begin tk(); n++; end
    chk("dv_seen", dv_cnt != c0, 1);
  endtask

  initial begin : main
    int d0, v0, n, ec, fall, ngap, ndv;
    bit bp, seen;
    int tq [$];
    tk(3);
    chk("rst_busy", busy, 0); chk("rst_den", drp_den, 0); chk("rst_addr", drp_daddr, 0);
    chk("rst_dv", data_valid, 0); chk("rst_data", ch_data, 0); chk("rst_err", timeout_err, 0);
    ARESETN = 1; tk(2);
    // single scan with fixed samples
    sq = '{16'h1230, 16'h1240, 16'h1250, 16'h1260, 16'hABC0, 16'hABC0, 16'hABC0, 16'hABC0};
    d0 = den_cnt;
    pulse_start();
    wait_dv(500);
    chk("t2_data", ch_data, 24'hABC124);
    chk("t2_den", den_cnt - d0, 8);
    chk("t2_err", timeout_err, 0);
    tk(10);
    // ch1 never answers
    drop1 = 1;
    pulse_start();
    wait_dv(2000);
    chk("t3_ch1_kept", ch_data[23:12], 12'hABC);
    chk("t3_err", timeout_err, 1);
    err_clr = 1; tk(); err_clr = 0;
    chk("t3_err_clr", timeout_err, 0);
    // err_clr held high: every timeout must still show for one cycle
    err_clr = 1; ec = 0; n = 0; v0 = dv_cnt;
    pulse_start();
    while (dv_cnt == v0 && n < 2000) begin ec += timeout_err ? 1 : 0; tk(); n++; end
    err_clr = 0;
    chk("t3_set_wins", ec, 4);
    chk("t3b_ch1_kept", ch_data[23:12], 12'hABC);
    drop1 = 0;
    tk(5);
    // centre window
    sq = '{16'h8200, 16'h8200, 16'h8200, 16'h8200, 16'h8600, 16'h8600, 16'h8600, 16'h8600};
    pulse_start();
    wait_dv(500);
    chk("t6_data", ch_data, {12'h860, DZ820});
    // random single scans with start spam while busy
    rnd_dly = 1;
    for (int k = 0; k < 6; k++) begin
      v0 = dv_cnt;
      pulse_start();
      n = 0;
      while (dv_cnt == v0 && n < 1500) begin start = (n % 5 == 4); tk(); n++; end
      start = 0;
      tk(20);
      chk("rnd_one_dv", dv_cnt - v0, 1);
      chk("rnd_idle", busy, 0);
    end
    rnd_dly = 0;
    // reset mid-scan
    dly = 20;
    pulse_start();
    tk(30);
    chk("mid_busy", busy, 1);
    #2 ARESETN = 0;
    #1;
    chk("mrst_busy", busy, 0); chk("mrst_den", drp_den, 0); chk("mrst_addr", drp_daddr, 0);
    chk("mrst_dv", data_valid, 0); chk("mrst_data", ch_data, 0); chk("mrst_err", timeout_err, 0);
    tk(3);
    ARESETN = 1;
    tk(2);
    chk("rel_busy", busy, 0); chk("rel_den", drp_den, 0); chk("rel_data", ch_data, 0);
    // periodic scanning, start pulses ignored
    dly = 3;
    scan_en = 1;
    v0 = dv_cnt; n = 0;
    while (tq.size() < 5 && n < 1300) begin
      start = (n % 37 == 5);
      tk(); n++;
      if (dv_cnt != v0) begin tq.push_back(cyc); v0 = dv_cnt; end
    end
    start = 0;
    chk("per_count", tq.size(), 5);
    for (int i = 1; i < tq.size(); i++) chk("per_interval", tq[i] - tq[i-1], 200);
    // overrun: each scan outlasts the period
    while (busy) tk();
    dly = 30;
    wait_dv(700);
    fall = cyc; bp = 0; ngap = 0; ndv = 0; n = 0; v0 = dv_cnt;
    while (ndv < 5 && n < 1800) begin
      tk(); n++;
      if (bp && !busy) fall = cyc;
      if (!bp && busy) begin chk("ovr_gap", cyc - fall, 1); ngap++; end
      if (dv_cnt != v0) begin ndv++; v0 = dv_cnt; end
      bp = busy;
    end
    chk("ovr_dv", ndv, 5);
    chk("ovr_scans", ngap, 5);
    // scan_en drops during an outstanding read
    d0 = den_cnt; n = 0;
    while (den_cnt == d0 && n < 100) begin tk(); n++; end
    chk("drop_den_seen", den_cnt != d0, 1);
    tk(5);
    scan_en = 0;
    d0 = den_cnt; v0 = dv_cnt; seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (drp_drdy && !seen) begin chk("drop_busy_at_drdy", busy, 1); seen = 1; end
      tk();
    end
    chk("drop_drdy", seen, 1);
    chk("drop_no_den", den_cnt - d0, 0);
    chk("drop_no_dv", dv_cnt - v0, 0);
    chk("drop_idle", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
